// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetches instruction/address bytes from the rx FIFO,
// decodes them and issues one datapath command at a time.
module instr_sequencer #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int INSTR_WIDTH     = 16,
  parameter int ADDRESS_SIZE    = 10,
  parameter int OPCODE_WIDTH    = 4,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       rx_empty,
  input  logic [FIFO_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_re,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [OPCODE_WIDTH-1:0]    cmd_op,
  output logic [ADDRESS_SIZE-1:0]    cmd_addr,
  output logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       cmd_relu,
  input  logic                       op_done,
  output logic                       busy,
  output logic                       halted,
  output logic                       err,
  output logic [15:0]                instr_count
);

  localparam int INSTR_BYTES = (INSTR_WIDTH + FIFO_DATA_WIDTH - 1) / FIFO_DATA_WIDTH;
  localparam int ADDR_BYTES  = (ADDRESS_SIZE + FIFO_DATA_WIDTH - 1) / FIFO_DATA_WIDTH;
  localparam int INSTR_SPAN  = INSTR_BYTES * FIFO_DATA_WIDTH;
  localparam int ADDR_SPAN   = ADDR_BYTES * FIFO_DATA_WIDTH;
  localparam int CNT_W       = 8;
  localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BYTES - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP     = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD    = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_COMPUTE = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT    = OPCODE_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE, FETCH_INSTR, FETCH_ADDR, DECODE, ISSUE, WAIT_DONE, HALT, ERROR
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [OPCODE_WIDTH-1:0]   op_q, op_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic                      relu_q, relu_d;
  logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
  logic [15:0]               count_q, count_d;
  logic                      first_byte;
  int                        lane_shift;

  // Each byte lands at its little-endian lane; only the decoded fields are kept,
  // so bits outside the fields (and above the word width) fall away naturally.
  assign first_byte = (byte_cnt_q == '0);
  assign lane_shift = int'(byte_cnt_q) * FIFO_DATA_WIDTH;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = '0;
    op_d       = op_q;
    len_d      = len_q;
    relu_d     = relu_q;
    addr_d     = addr_q;
    count_d    = count_q;
    rx_re      = 1'b0;
    cmd_valid  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = FETCH_INSTR;
      FETCH_INSTR: begin
        byte_cnt_d = byte_cnt_q;
        if (!rx_empty) begin
          rx_re  = 1'b1;
          op_d   = (first_byte ? '0 : op_q)
                 | OPCODE_WIDTH'(INSTR_SPAN'(rx_data) << lane_shift >> (INSTR_WIDTH - OPCODE_WIDTH));
          len_d  = (first_byte ? '0 : len_q) | LEN_WIDTH'(INSTR_SPAN'(rx_data) << lane_shift);
          relu_d = (first_byte ? 1'b0 : relu_q) | 1'(INSTR_SPAN'(rx_data) << lane_shift >> LEN_WIDTH);
          if (byte_cnt_q == INSTR_LAST) begin
            byte_cnt_d = '0;
            state_d    = DECODE;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      FETCH_ADDR: begin
        byte_cnt_d = byte_cnt_q;
        if (!rx_empty) begin
          rx_re  = 1'b1;
          addr_d = (first_byte ? '0 : addr_q) | ADDRESS_SIZE'(ADDR_SPAN'(rx_data) << lane_shift);
          if (byte_cnt_q == ADDR_LAST) begin
            byte_cnt_d = '0;
            state_d    = ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      DECODE: begin
        case (op_q)
          OP_NOP: begin
            state_d = FETCH_INSTR;
            count_d = count_q + 16'd1;
          end
          OP_LOAD, OP_STORE: begin
            if (len_q == '0) begin
              state_d = FETCH_INSTR;
              count_d = count_q + 16'd1;
            end else begin
              state_d = FETCH_ADDR;
            end
          end
          OP_COMPUTE: state_d = FETCH_ADDR;
          OP_HALT: begin
            state_d = HALT;
            count_d = count_q + 16'd1;
          end
          default: state_d = ERROR;
        endcase
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (op_done) begin
          state_d = FETCH_INSTR;
          count_d = count_q + 16'd1;
        end
      end
      HALT:  if (start) state_d = FETCH_INSTR;
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      op_q       <= '0;
      len_q      <= '0;
      relu_q     <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      op_q       <= op_d;
      len_q      <= len_d;
      relu_q     <= relu_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
    end
  end

  assign cmd_op      = op_q;
  assign cmd_addr    = addr_q;
  assign cmd_len     = len_q;
  assign cmd_relu    = relu_q;
  assign instr_count = count_q;
  assign busy        = (state_q != IDLE) && (state_q != HALT) && (state_q != ERROR);
  assign halted      = (state_q == HALT);
  assign err         = (state_q == ERROR);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized program runs plus directed cases for instr_sequencer,
// checked against a transaction-level model of the expected command stream.
module tb_instr_sequencer;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic        rx_empty = 1'b1, rx_re;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_valid, cmd_ready = 1'b0, cmd_relu, op_done = 1'b0;
  logic [3:0]  cmd_op;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        busy, halted, err;
  logic [15:0] instr_count;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .rx_empty(rx_empty), .rx_data(rx_data), .rx_re(rx_re),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_relu(cmd_relu), .op_done(op_done), .busy(busy), .halted(halted),
    .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {int op; int addr; int len; int relu; int cnt;} cmd_t;
  cmd_t sb[$];
  int   fifo[$];
  int   total = 0, bad = 0;
  int   stall_mode = 0, ready_mode = 0, done_wait = 0, done_cnt = 0, model_count = 0;
  bit   hold_done = 0, spur_done = 1, pop_pend = 0, outstanding = 0, tog = 0, stall = 0;
  bit   prev_wait = 0;
  logic [3:0] p_op;
  logic [9:0] p_addr;
  logic [7:0] p_len;
  logic       p_relu;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int word(input int op, input int len, input int relu);
    return (op << 12) | (relu << 8) | len;
  endfunction

  // Environment: FIFO, datapath ready/op_done, and the per-cycle compare.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
      pop_pend = 0;
      tog = ~tog;
      case (stall_mode)
        0: stall = 0;
        1: stall = ($urandom_range(0, 2) == 0);
        default: stall = tog;
      endcase
      rx_empty = (fifo.size() == 0) || stall;
      rx_data  = (fifo.size() > 0) ? 8'(fifo[0]) : 8'($urandom);
      if (ready_mode == 0) cmd_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2) cmd_ready = 1'b1;
      if (!hold_done) begin
        op_done = 1'b0;
        if (outstanding) begin
          if (done_wait == 0) begin
            op_done = 1'b1;
            outstanding = 0;
            done_cnt++;
          end else done_wait--;
        end else if (spur_done && $urandom_range(0, 6) == 0) op_done = 1'b1;
      end
      #3;
      if (rst) begin
        pop_pend = rx_re;
        if (rx_re) begin
          chk("rx_re_while_empty", rx_empty, 0);
          chk("rx_re_while_not_busy", busy, 1);
        end
        chk("status_exclusive", (32'(busy) + 32'(halted) + 32'(err)) <= 1, 1);
        if (cmd_valid) begin
          chk("valid_expected", sb.size() > 0, 1);
          if (prev_wait) begin
            chk("hold_op", cmd_op, p_op);
            chk("hold_addr", cmd_addr, p_addr);
            chk("hold_len", cmd_len, p_len);
            chk("hold_relu", cmd_relu, p_relu);
          end
          if (cmd_ready) begin
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("cmd_op", cmd_op, e.op);
              chk("cmd_addr", cmd_addr, e.addr);
              chk("cmd_len", cmd_len, e.len);
              chk("cmd_relu", cmd_relu, e.relu);
              chk("count_at_issue", instr_count, e.cnt);
            end
            outstanding = 1;
            done_wait = $urandom_range(0, 4);
          end
        end
        prev_wait = cmd_valid && !cmd_ready;
        p_op = cmd_op; p_addr = cmd_addr; p_len = cmd_len; p_relu = cmd_relu;
      end else begin
        pop_pend = 0;
        prev_wait = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_env();
    sb.delete(); fifo.delete();
    outstanding = 0; pop_pend = 0; prev_wait = 0; model_count = 0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0; start = 1'b0; op_done = 1'b0;
    clear_env();
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Model: encode one instruction into FIFO bytes and predict the command it yields.
  task automatic push_instr(input int op, input int len, input int relu, input int addr);
    int w, a;
    w = word(op, len, relu) | ($urandom_range(0, 7) << 9);
    fifo.push_back(w & 255);
    fifo.push_back((w >> 8) & 255);
    if (op == 2 || ((op == 1 || op == 3) && len != 0)) begin
      a = addr | ($urandom_range(0, 63) << 10);
      fifo.push_back(a & 255);
      fifo.push_back((a >> 8) & 255);
      sb.push_back('{op, addr & 1023, len, relu, model_count});
    end
    model_count = (model_count + 1) & 16'hFFFF;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int k = 0;
    while (!halted && k < budget) begin cyc(); k++; end
    if (k >= budget) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done_from(input string name, input int base, input int budget);
    int k = 0;
    while (done_cnt <= base && k < budget) begin cyc(); k++; end
    if (k >= budget) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic random_round(input int n);
    int op, len;
    for (int i = 0; i < n; i++) begin
      op  = $urandom_range(0, 3);
      len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      push_instr(op, len, $urandom_range(0, 1), $urandom_range(0, 1023));
    end
    push_instr(4, 0, 0, 0);
    pulse_start();
    wait_halted("rand_halt", 4000);
    chk("rand_halted", halted, 1);
    chk("rand_count", instr_count, model_count);
    chk("rand_cmds_left", sb.size(), 0);
    chk("rand_fifo_left", fifo.size(), 0);
  endtask

  task automatic push_load_literal();
    fifo.push_back(8'h04); fifo.push_back(8'h10); fifo.push_back(8'h23); fifo.push_back(8'h01);
    sb.push_back('{1, 'h123, 4, 0, 0});
  endtask

  initial begin
    int base, k;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_rx_re", rx_re, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_halted_err", {halted, err}, 0);
    chk("pin_load_word", word(1, 4, 0), 'h1004);
    chk("pin_compute_word", word(2, 0, 1), 'h2100);
    rst = 1'b1;

    // LOAD, stall-free then with rx_empty toggling between bytes
    for (int m = 0; m < 2; m++) begin
      do_reset();
      stall_mode = (m == 0) ? 0 : 2;
      push_load_literal();
      base = done_cnt;
      pulse_start();
      wait_done_from("load_done", base, 200);
      cyc();
      chk("load_count", instr_count, 1);
      chk("load_cmds_left", sb.size(), 0);
    end
    stall_mode = 0;

    // COMPUTE with relu, ready withheld for 5 valid cycles
    do_reset();
    ready_mode = 1; cmd_ready = 1'b0;
    fifo.push_back(8'h00); fifo.push_back(8'h21); fifo.push_back(8'h00); fifo.push_back(8'h00);
    sb.push_back('{2, 0, 0, 1, 0});
    pulse_start();
    k = 0;
    while (!cmd_valid && k < 50) begin cyc(); k++; end
    chk("compute_valid_seen", cmd_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("compute_valid_held", cmd_valid, 1);
    end
    cyc();
    chk("compute_valid_cycle6", cmd_valid, 1);
    cmd_ready = 1'b1;
    base = done_cnt;
    cyc();
    cmd_ready = 1'b0; ready_mode = 0;
    chk("compute_accepted", cmd_valid, 0);
    wait_done_from("compute_done", base, 50);
    cyc();
    chk("compute_count", instr_count, 1);

    // randomized programs; second run resumes from HALT with the count kept
    do_reset();
    stall_mode = 1;
    random_round(25);
    random_round(20);
    stall_mode = 0;

    // zero-length STORE then HALT
    do_reset();
    fifo.push_back(8'h00); fifo.push_back(8'h30); fifo.push_back(8'h00); fifo.push_back(8'h40);
    pulse_start();
    wait_halted("zl_halt", 100);
    chk("zl_halted", halted, 1);
    chk("zl_count", instr_count, 2);
    chk("zl_busy", busy, 0);
    pulse_start();
    chk("zl_restart_busy", busy, 1);
    chk("zl_restart_halted", halted, 0);

    // illegal opcode
    do_reset();
    fifo.push_back(8'h00); fifo.push_back(8'hF0);
    fifo.push_back(8'h11); fifo.push_back(8'h22); fifo.push_back(8'h33);
    pulse_start();
    k = 0;
    while (fifo.size() != 3 && k < 50) begin cyc(); k++; end
    cyc();
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    repeat (10) cyc();
    chk("ill_no_more_pops", fifo.size(), 3);
    chk("ill_err_held", err, 1);
    do_reset();
    chk("ill_err_cleared", err, 0);

    // reset while waiting for op_done
    do_reset();
    hold_done = 1; op_done = 1'b0;
    push_instr(0, 0, 0, 0);
    push_instr(1, 7, 1, 'h2AB);
    pulse_start();
    k = 0;
    while (!outstanding && k < 100) begin cyc(); k++; end
    chk("wd_issued", outstanding, 1);
    cyc(); cyc();
    chk("wd_busy", busy, 1);
    chk("wd_count", instr_count, 1);
    rst = 1'b0;
    #1;
    chk("wd_rst_rx_re", rx_re, 0);
    chk("wd_rst_valid", cmd_valid, 0);
    chk("wd_rst_payload", {cmd_op, cmd_addr, cmd_len, cmd_relu}, 0);
    chk("wd_rst_status", {busy, halted, err}, 0);
    chk("wd_rst_count", instr_count, 0);
    clear_env();
    cyc();
    rst = 1'b1;
    cyc();
    op_done = 1'b1;
    cyc();
    op_done = 1'b0;
    repeat (3) cyc();
    chk("wd_after_count", instr_count, 0);
    chk("wd_after_busy", busy, 0);
    chk("wd_after_valid", cmd_valid, 0);
    hold_done = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DATA_WIDTH, default 8, width of one byte read from the receive FIFO.
REQ-002 SHALL have parameter INSTR_WIDTH, default 16, instruction word width; constraint INSTR_WIDTH >= OPCODE_WIDTH+LEN_WIDTH+1.
REQ-003 SHALL have parameter ADDRESS_SIZE, default 10, unified-buffer address width.
REQ-004 SHALL have parameter OPCODE_WIDTH, default 4, opcode field width.
REQ-005 SHALL have parameter LEN_WIDTH, default 8, transfer-length field width.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port: start  in  1  begin or resume fetching.
REQ-009 SHALL have ports: rx_empty  in  1  receive FIFO empty; rx_data  in  FIFO_DATA_WIDTH  FIFO head byte, first-word-fall-through; rx_re  out  1  pop head byte.
REQ-010 SHALL have ports: cmd_valid  out  1; cmd_ready  in  1; cmd_op  out  OPCODE_WIDTH; cmd_addr  out  ADDRESS_SIZE; cmd_len  out  LEN_WIDTH; cmd_relu  out  1 -- datapath command channel.
REQ-011 SHALL have port: op_done  in  1  single-cycle pulse, datapath finished the issued command.
REQ-012 SHALL have ports: busy  out  1; halted  out  1; err  out  1; instr_count  out  16.

Function
REQ-013 SHALL use states IDLE, FETCH_INSTR, FETCH_ADDR, DECODE, ISSUE, WAIT_DONE, HALT, ERROR.
REQ-014 SHALL assert rx_re combinationally only in FETCH_INSTR/FETCH_ADDR when rx_empty=0, capturing rx_data on that edge; max one byte per cycle; stall while rx_empty=1.
REQ-015 SHALL assemble an instruction from INSTR_BYTES = ceil(INSTR_WIDTH/FIFO_DATA_WIDTH) bytes, little-endian; excess high bits discarded.
REQ-016 SHALL decode fields: opcode = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH]; len = instr[LEN_WIDTH-1:0]; relu = instr[LEN_WIDTH].
REQ-017 SHALL use opcodes 0 NOP, 1 LOAD, 2 COMPUTE, 3 STORE, 4 HALT; all others illegal.
REQ-018 SHALL move IDLE->FETCH_INSTR on start=1; start ignored in all other states except HALT.
REQ-019 SHALL enter DECODE the cycle after the last instruction byte is captured; DECODE lasts exactly one cycle.
REQ-020 SHALL in DECODE: NOP, or LOAD/STORE with len=0 -> FETCH_INSTR (no issue); HALT -> HALT; LOAD/COMPUTE/STORE otherwise -> FETCH_ADDR; illegal -> ERROR.
REQ-021 SHALL assemble cmd_addr from ADDR_BYTES = ceil(ADDRESS_SIZE/FIFO_DATA_WIDTH) bytes, little-endian, bits above ADDRESS_SIZE discarded; enter ISSUE the cycle after the last byte.
REQ-022 SHALL hold cmd_valid=1 in ISSUE with cmd_op/addr/len/relu stable until cmd_valid&cmd_ready, then go to WAIT_DONE next cycle.
REQ-023 SHALL ignore op_done outside WAIT_DONE, including in the handshake cycle; op_done in WAIT_DONE -> FETCH_INSTR.
REQ-024 SHALL increment instr_count (wrapping 0xFFFF->0) on: DECODE exit for NOP, zero-length LOAD/STORE, and HALT; op_done in WAIT_DONE.
REQ-025 SHALL leave HALT for FETCH_INSTR on start=1, with instr_count preserved.
REQ-026 SHALL hold ERROR until reset; rx_re=0 and cmd_valid=0 there.
REQ-027 SHALL drive busy=1 in all states other than IDLE, HALT and ERROR; halted=1 only in HALT; err=1 only in ERROR.
REQ-028 SHALL restart byte assembly from byte 0 on every entry to FETCH_INSTR/FETCH_ADDR.

Reset
REQ-029 SHALL on rst=0, immediately and asynchronously: state IDLE; rx_re=0, cmd_valid=0, cmd_op/addr/len/relu=0, busy=0, halted=0, err=0, instr_count=0, byte counters and assembly registers 0.
REQ-030 SHALL abandon any in-flight fetch or command on reset mid-operation, with no cmd_valid pulse after deassertion until a new instruction is fully fetched.

Verification
REQ-031 SHALL cover LOAD: start, bytes 0x04,0x10,0x23,0x01 -> one cmd_valid with op=1, addr=0x123, len=4, relu=0; after op_done, instr_count=1.
REQ-032 SHALL cover COMPUTE with relu: bytes 0x00,0x21,0x00,0x00; cmd_ready held 0 for 5 cycles -> cmd_valid and payload stable 5 cycles, op=2, relu=1, accepted on cycle 6.
REQ-033 SHALL cover FIFO stalls: rx_empty toggled between every byte -> rx_re never asserted while rx_empty=1, command identical to stall-free case.
REQ-034 SHALL cover zero length and HALT: STORE len 0 (0x00,0x30), then HALT (0x00,0x40) -> no cmd_valid, halted=1, instr_count=2; start -> busy=1.
REQ-035 SHALL cover illegal opcode: bytes 0x00,0xF0 -> err=1 within 1 cycle of DECODE, no further rx_re; rst=0 clears err.
REQ-036 SHALL cover reset mid-WAIT_DONE: rst pulsed low -> all outputs at reset values; a later op_done is ignored.
